// File: rtl/powlib_sfifo_pkg.sv
// Shared helpers for the powlib synchronous FIFO.
// Provides the ceiling-log2 sizing function.
package powlib_sfifo_pkg;

  function automatic int powlib_clogb2(input int x);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < x) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/powlib_cntr.sv
// Up counter with synchronous clear and optional load.
// clr has priority over load and advance.
module powlib_cntr #(
  parameter int W   = 1,
  parameter int ELD = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         adv,
  input  logic         ld,
  input  logic [W-1:0] nval,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if ((ELD != 0) && ld) begin
      r_cnt <= nval;
    end else if (adv) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/powlib_dpram.sv
// Dual-port RAM, one write and one read port.
// Read is either combinational or registered.
module powlib_dpram
  import powlib_sfifo_pkg::*;
#(
  parameter int W      = 32,
  parameter int D      = 8,
  parameter int ERRD   = 0,
  parameter int EASYNC = 0,
  parameter int EWBE   = 0,
  parameter int ERDRDY = 0,
  parameter int WA     = powlib_clogb2(D),
  parameter int BEW    = (W + 7) / 8
) (
  input  logic           wrclk,
  input  logic           rdclk,
  input  logic [W-1:0]   wrdata,
  input  logic           wrvld,
  input  logic [BEW-1:0] wrbe,
  input  logic [WA-1:0]  wraddr,
  input  logic [WA-1:0]  rdaddr,
  input  logic           rdrdy,
  output logic [W-1:0]   rddata
);

  logic [W-1:0] r_mem [D];
  logic [W-1:0] r_rddata;
  logic [W-1:0] w_mask;
  logic         w_rdclk;

  always_comb begin
    w_mask = '1;
    if (EWBE != 0) begin
      for (int i = 0; i < W; i++) begin
        w_mask[i] = wrbe[i/8];
      end
    end
  end

  always_ff @(posedge wrclk) begin
    if (wrvld) begin
      r_mem[wraddr] <= (r_mem[wraddr] & ~w_mask)
                     | (wrdata & w_mask);
    end
  end

  // Same-clock configurations keep the read register on wrclk.
  assign w_rdclk = (EASYNC != 0) ? rdclk : wrclk;

  always_ff @(posedge w_rdclk) begin
    if ((ERDRDY == 0) || rdrdy) begin
      r_rddata <= r_mem[rdaddr];
    end
  end

  assign rddata = (ERRD != 0) ? r_rddata : r_mem[rdaddr];

endmodule

// File: rtl/powlib_sfifo.sv
// Single-clock first-word-fall-through FIFO.
// Occupancy is tracked explicitly; pointers wrap at D-1.
module powlib_sfifo
  import powlib_sfifo_pkg::*;
#(
  parameter int W     = 32,
  parameter int D     = 8,
  parameter int AFULL = D - 2,
  parameter int WIDX  = powlib_clogb2(D),
  parameter int WCNT  = powlib_clogb2(D + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [W-1:0]    wrdata,
  input  logic            wrvld,
  output logic            wrrdy,
  output logic            wrafull,
  output logic [W-1:0]    rddata,
  output logic            rdvld,
  input  logic            rdrdy,
  output logic [WCNT-1:0] count
);

  localparam int BEW = (W + 7) / 8;

  logic [WIDX-1:0] w_wrptr;
  logic [WIDX-1:0] w_rdptr;
  logic [WCNT-1:0] r_count;
  logic            w_wr;
  logic            w_rd;
  logic            w_wrwrap;
  logic            w_rdwrap;

  assign wrrdy   = (r_count != WCNT'(D)) && !rst;
  assign rdvld   = (r_count != '0) && !rst;
  assign wrafull = r_count >= WCNT'(AFULL);
  assign count   = r_count;

  assign w_wr = wrvld && wrrdy;
  assign w_rd = rdvld && rdrdy;

  assign w_wrwrap = w_wr && (w_wrptr == WIDX'(D - 1));
  assign w_rdwrap = w_rd && (w_rdptr == WIDX'(D - 1));

  powlib_cntr #(
    .W   (WIDX),
    .ELD (0)
  ) wrptr_inst (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_wrwrap),
    .adv  (w_wr),
    .ld   (1'b0),
    .nval ('0),
    .cnt  (w_wrptr)
  );

  powlib_cntr #(
    .W   (WIDX),
    .ELD (0)
  ) rdptr_inst (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_rdwrap),
    .adv  (w_rd),
    .ld   (1'b0),
    .nval ('0),
    .cnt  (w_rdptr)
  );

  // wr and rd both require !rst, so the arms never overlap.
  always_ff @(posedge clk) begin
    unique case (1'b1)
      rst:            r_count <= '0;
      w_wr && !w_rd:  r_count <= r_count + WCNT'(1);
      w_rd && !w_wr:  r_count <= r_count - WCNT'(1);
      default:        ;
    endcase
  end

  powlib_dpram #(
    .W      (W),
    .D      (D),
    .ERRD   (0),
    .EASYNC (0),
    .EWBE   (0),
    .ERDRDY (0)
  ) ram_inst (
    .wrclk  (clk),
    .rdclk  (clk),
    .wrdata (wrdata),
    .wrvld  (w_wr),
    .wrbe   ({BEW{1'b0}}),
    .wraddr (w_wrptr),
    .rdaddr (w_rdptr),
    .rdrdy  (w_rd),
    .rddata (rddata)
  );

endmodule

// File: tb/tb_powlib_sfifo.sv
// Self-checking bench for powlib_sfifo.
// Queue reference model, D=8 and D=5 instances.
module tb_powlib_sfifo;

  logic        clk;
  logic        rst8, wv8, wr8, af8, rv8, rr8;
  logic [31:0] wd8, rd8;
  logic [3:0]  cnt8;
  logic        rst5, wv5, wr5, af5, rv5, rr5;
  logic [15:0] wd5, rd5;
  logic [2:0]  cnt5;

  logic [31:0] q8[$];
  logic [15:0] q5[$];
  int checks = 0;
  int errors = 0;

  powlib_sfifo #(.W(32), .D(8), .AFULL(6)) dut8 (
    .clk(clk), .rst(rst8), .wrdata(wd8), .wrvld(wv8),
    .wrrdy(wr8), .wrafull(af8), .rddata(rd8),
    .rdvld(rv8), .rdrdy(rr8), .count(cnt8)
  );

  powlib_sfifo #(.W(16), .D(5), .AFULL(3)) dut5 (
    .clk(clk), .rst(rst5), .wrdata(wd5), .wrvld(wv5),
    .wrrdy(wr5), .wrafull(af5), .rddata(rd5),
    .rdvld(rv5), .rdrdy(rr5), .count(cnt5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic tick8();
    bit w, r, rs;
    logic [31:0] d;
    rs = rst8;
    w  = wv8 && !rs && (q8.size() < 8);
    r  = rr8 && !rs && (q8.size() > 0);
    d  = wd8;
    @(posedge clk); #1;
    if (rs) q8.delete();
    else begin
      if (r) void'(q8.pop_front());
      if (w) q8.push_back(d);
    end
  endtask

  task automatic tick5();
    bit w, r, rs;
    logic [15:0] d;
    rs = rst5;
    w  = wv5 && !rs && (q5.size() < 5);
    r  = rr5 && !rs && (q5.size() > 0);
    d  = wd5;
    @(posedge clk); #1;
    if (rs) q5.delete();
    else begin
      if (r) void'(q5.pop_front());
      if (w) q5.push_back(d);
    end
  endtask

  task automatic test_reset();
    rst8 = 1; wv8 = 0; rr8 = 0; wd8 = '0;
    tick8(); tick8();
    checks++;
    if (wr8 !== 1'b0 || rv8 !== 1'b0) begin
      errors++;
      $display("FAIL rst_hold wrrdy=%b rdvld=%b exp 0 0", wr8, rv8);
    end
    rst8 = 0; #1;
    checks++;
    if ({wr8, rv8, af8} !== 3'b100 || cnt8 !== 4'd0) begin
      errors++;
      $display("FAIL rst_out wrrdy/rdvld/afull=%b%b%b cnt=%0d exp 100 0",
               wr8, rv8, af8, cnt8);
    end
  endtask

  task automatic test_fill();
    rr8 = 0;
    for (int i = 1; i <= 8; i++) begin
      wd8 = 32'(i); wv8 = 1;
      tick8();
      checks++;
      if (int'(cnt8) != i || af8 !== (i >= 6) || wr8 !== (i < 8)) begin
        errors++;
        $display("FAIL fill%0d cnt=%0d af=%b rdy=%b exp %0d %b %b",
                 i, cnt8, af8, wr8, i, i >= 6, i < 8);
      end
    end
    wd8 = 32'd9;
    tick8();
    wv8 = 0;
    checks++;
    if (cnt8 !== 4'd8 || rd8 !== 32'd1) begin
      errors++;
      $display("FAIL overflow cnt=%0d head=%0h exp 8 1", cnt8, rd8);
    end
  endtask

  task automatic test_drain();
    wv8 = 0; rr8 = 1;
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (rv8 !== 1'b1 || rd8 !== 32'(i)) begin
        errors++;
        $display("FAIL drain%0d vld=%b data=%0h exp 1 %0h", i, rv8, rd8, i);
      end
      tick8();
    end
    tick8();
    rr8 = 0;
    checks++;
    if (rv8 !== 1'b0 || cnt8 !== 4'd0) begin
      errors++;
      $display("FAIL drain_end vld=%b cnt=%0d exp 0 0", rv8, cnt8);
    end
  endtask

  task automatic test_simul();
    rr8 = 0; wv8 = 1;
    for (int i = 0; i < 3; i++) begin
      wd8 = 32'h100 + 32'(i); tick8();
    end
    rr8 = 1;
    for (int i = 0; i < 10; i++) begin
      wd8 = $urandom;
      checks++;
      if (rd8 !== q8[0] || cnt8 !== 4'd3) begin
        errors++;
        $display("FAIL simul%0d data=%0h cnt=%0d exp %0h 3",
                 i, rd8, cnt8, q8[0]);
      end
      tick8();
    end
    wv8 = 0;
    while (q8.size() > 0) tick8();
    rr8 = 0;
  endtask

  task automatic test_full_read();
    rr8 = 0; wv8 = 1;
    for (int i = 0; i < 8; i++) begin
      wd8 = 32'h10 + 32'(i); tick8();
    end
    wd8 = 32'hAA; rr8 = 1;
    checks++;
    if (wr8 !== 1'b0) begin
      errors++;
      $display("FAIL full_rdy wrrdy=%b exp 0", wr8);
    end
    tick8();
    checks++;
    if (cnt8 !== 4'd7) begin
      errors++;
      $display("FAIL full_rd cnt=%0d exp 7", cnt8);
    end
    rr8 = 0;
    tick8();
    wv8 = 0;
    checks++;
    if (cnt8 !== 4'd8) begin
      errors++;
      $display("FAIL full_pend cnt=%0d exp 8", cnt8);
    end
    rr8 = 1;
    while (q8.size() > 0) begin
      checks++;
      if (rv8 !== 1'b1 || rd8 !== q8[0]) begin
        errors++;
        $display("FAIL full_order data=%0h exp %0h", rd8, q8[0]);
      end
      tick8();
    end
    rr8 = 0;
  endtask

  task automatic test_reset_mid();
    wv8 = 1; rr8 = 0;
    for (int i = 0; i < 5; i++) begin
      wd8 = 32'h200 + 32'(i); tick8();
    end
    rst8 = 1; rr8 = 1; wd8 = 32'h77; #1;
    checks++;
    if (wr8 !== 1'b0 || rv8 !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst wrrdy=%b rdvld=%b exp 0 0", wr8, rv8);
    end
    tick8();
    rst8 = 0; wv8 = 0; rr8 = 0; #1;
    checks++;
    if (cnt8 !== 4'd0 || rv8 !== 1'b0 || wr8 !== 1'b1) begin
      errors++;
      $display("FAIL mid_after cnt=%0d vld=%b rdy=%b exp 0 0 1",
               cnt8, rv8, wr8);
    end
    wd8 = 32'h55; wv8 = 1; #1;
    checks++;
    if (rv8 !== 1'b0) begin
      errors++;
      $display("FAIL no_bypass rdvld=%b exp 0", rv8);
    end
    tick8();
    wv8 = 0;
    checks++;
    if (rv8 !== 1'b1 || rd8 !== 32'h55 || cnt8 !== 4'd1) begin
      errors++;
      $display("FAIL mid_first vld=%b data=%0h cnt=%0d exp 1 55 1",
               rv8, rd8, cnt8);
    end
  endtask

  task automatic test_wrap();
    int sent, got, cyc;
    rst5 = 1; wv5 = 0; rr5 = 0; wd5 = '0;
    tick5();
    rst5 = 0;
    sent = 0; got = 0; cyc = 0;
    while (got < 100 && cyc < 3000) begin
      wv5 = (sent < 100) && ($urandom_range(0, 3) != 0);
      wd5 = 16'(sent);
      rr5 = ($urandom_range(0, 2) != 0);
      #1;
      checks++;
      if (int'(cnt5) != q5.size() || wr5 !== (q5.size() < 5)
          || af5 !== (q5.size() >= 3)) begin
        errors++;
        $display("FAIL wrap_cnt c%0d cnt=%0d rdy=%b af=%b exp %0d",
                 cyc, cnt5, wr5, af5, q5.size());
      end
      checks++;
      if (q5.size() > 0) begin
        if (rv5 !== 1'b1 || rd5 !== q5[0]) begin
          errors++;
          $display("FAIL wrap_data c%0d vld=%b data=%0h exp 1 %0h",
                   cyc, rv5, rd5, q5[0]);
        end
      end else if (rv5 !== 1'b0) begin
        errors++;
        $display("FAIL wrap_empty c%0d vld=%b exp 0", cyc, rv5);
      end
      if (wv5 && q5.size() < 5) sent++;
      if (rr5 && q5.size() > 0) got++;
      tick5();
      cyc++;
    end
    wv5 = 0; rr5 = 0;
    checks++;
    if (got != 100) begin
      errors++;
      $display("FAIL wrap_total got=%0d exp 100", got);
    end
  endtask

  initial begin
    rst8 = 1; wv8 = 0; rr8 = 0; wd8 = '0;
    rst5 = 1; wv5 = 0; rr5 = 0; wd5 = '0;
    test_reset();
    test_fill();
    test_drain();
    test_simul();
    test_full_read();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/powlib_sfifo.md
Name: powlib_sfifo

Overview:
- Single-clock synchronous FIFO with valid/ready handshakes on the write and read sides.
- Storage is one powlib_dpram instance in synchronous, unregistered-read mode.
- First-word-fall-through: the head entry is presented on rddata whenever rdvld=1.
- Used as the elastic buffer between pipe stages and bus endpoints in the same clock domain.

Parameters:
- W, 32, data width in bits.
- D, 8, depth in entries. Must be >= 2; need not be a power of two.
- AFULL, D-2, almost-full threshold: wrafull=1 when count >= AFULL. Range 1..D.
- WIDX, powlib_clogb2(D), pointer width (derived; do not override).
- WCNT, powlib_clogb2(D+1), occupancy width (derived; do not override).

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  reset; synchronous, active-high.
- wrdata  input  W  write data.
- wrvld  input  1  write data valid.
- wrrdy  output  1  FIFO can accept a write this cycle.
- wrafull  output  1  occupancy >= AFULL.
- rddata  output  W  head-of-FIFO data; don't-care when rdvld=0.
- rdvld  output  1  FIFO non-empty; rddata is valid.
- rdrdy  input  1  consumer accepts head this cycle.
- count  output  WCNT  current occupancy, 0..D.

Behaviour:
- Handshakes:
  - Write transfer (wr) = wrvld && wrrdy.
  - Read transfer (rd) = rdvld && rdrdy.
  - Transfers are evaluated on the posedge.
- State registers: wrptr, rdptr (WIDX bits), count (WCNT bits). There is no separate FSM; state is implied by count:
  - EMPTY: count=0.
  - PARTIAL: 0 < count < D.
  - FULL: count=D.
- Derived outputs, combinational from registers and rst:
  - wrrdy = (count != D) && !rst.
  - rdvld = (count != 0) && !rst.
  - wrafull = count >= AFULL.
  - rddata = mem[rdptr] via dpram asynchronous read.
- Reset:
  - On a clk edge with rst=1: wrptr=0, rdptr=0, count=0. Memory contents are not cleared.
  - While rst=1: wrrdy=0 and rdvld=0, so no transfers occur.
  - The cycle after rst deasserts: wrrdy=1, rdvld=0, wrafull=0, count=0.
- Write path:
  - On wr: dpram writes wrdata at wrptr (wrvld to dpram = wr).
  - wrptr advances by 1, wrapping from D-1 to 0. The wrap is an explicit compare against D-1, not a modulo-2^WIDX overflow.
- Read path:
  - On rd: rdptr advances by 1 with the same wrap rule.
  - The new head appears on rddata in the following cycle.
- Latency:
  - A word written at edge n gives rdvld=1 and rddata=word after edge n (visible in cycle n+1).
  - No same-cycle bypass from wrdata to rddata when empty.
- Count update:
  - wr only: +1.
  - rd only: -1.
  - wr and rd together: unchanged.
  - Neither: unchanged.
- Boundary rules:
  - FULL: wrrdy=0, so a write is refused even if a read occurs in the same cycle. No write-through-when-full.
  - EMPTY: rdvld=0, so rdrdy is ignored. count never underflows or overflows.
  - Simultaneous wr and rd in PARTIAL: both pointers advance, count holds.
  - rddata is held stable while rdvld=1 and rdrdy=0.
- Ordering: strict FIFO order. No data loss, duplication or reordering under any wrvld/rdrdy pattern.

Decomposition:
- powlib_std.vh: supplies powlib_clogb2 (used for WIDX and WCNT). No new package constants are required.
- Sub-module: powlib_dpram instance "ram_inst" with .W(W), .D(D), .ERRD(0), .EASYNC(0), .EWBE(0), .ERDRDY(0). wrbe is tied to 0; wrclk and rdclk are tied to clk.
- Pointers: may be powlib_cntr instances with ELD=0, using clr for both rst and wrap-to-0. count may be a powlib_flipflop.

Test Plan:
- Fill and overflow, D=8, AFULL=6: write 1..8 back-to-back with rdrdy=0 -> wrafull rises after the 6th write, wrrdy=0 after the 8th, count=8. A 9th wrvld is refused and count stays 8.
- Drain: from the full state, rdrdy=1 for 8 cycles -> rddata sequence 1..8, rdvld=0 after the last read, count=0. Extra rdrdy has no effect.
- Simultaneous operations: with count=3, wr and rd each cycle for 10 cycles -> count stays 3 and output order is preserved.
- Full plus read: at count=8, wrvld=1 and rdrdy=1 in the same cycle -> only the read occurs, count=7, and the pending word is written next cycle.
- Wrap-around, D=5 (non-power-of-two): push 0..99 with randomised wrvld/rdrdy -> scoreboard matches all 100 words, with pointers wrapping 4->0.
- Reset mid-operation: count=5, assert rst for 1 cycle with wrvld=1 and rdrdy=1 -> next cycle count=0 and rdvld=0. During rst, wrrdy=0 and no word is stored. The first subsequent write appears in the cycle after it is accepted.
